occupancy_tracker: RTL and testbench

OCCUPANCY_TRACKER -- requirements
Module: occupancy_tracker

---
 rtl/occupancy_tracker.sv | 171 +++++++++++++++++
 tb/tb_occupancy_tracker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/occupancy_tracker.sv
// ---------------------------------------------------------------------------
// occupancy_tracker
//
// Turns a raw, glitchy bay-occupied sensor flag into a debounced occupancy
// flag. It emits one-cycle arrive/depart events and measures how long the
// current (or most recent) stay has lasted, in whole seconds.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change
//   TICK_CYCLES      clock cycles per parked-time second
//
// Ports
//   clk        in   system clock, rising-edge active
//   rst        in   asynchronous, active-high reset
//   parked     in   raw sensor flag, asynchronous to clk
//   occupied   out  debounced occupancy (high in OCCUPIED / DEPARTING)
//   arrive     out  one-cycle pulse when a car is accepted as parked
//   depart     out  one-cycle pulse when a car is accepted as gone
//   park_secs  out  seconds of the current / last stay, saturating at 65535
// ---------------------------------------------------------------------------
module occupancy_tracker #(
  parameter int DEBOUNCE_CYCLES = 5_000_000,
  parameter int TICK_CYCLES     = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        parked,
  output logic        occupied,
  output logic        arrive,
  output logic        depart,
  output logic [15:0] park_secs
);

  // A count of 1 would give a zero-width counter; keep at least one bit.
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [15:0]       SECS_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    ARRIVING  = 2'd1,
    OCCUPIED  = 2'd2,
    DEPARTING = 2'd3
  } state_e;

  // Saturating seconds increment: the counter sticks at full scale.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == SECS_MAX) ? v : v + 16'd1;
  endfunction

  // Registered state
  logic              sync1_q, sync2_q;
  state_e            state_q, state_d;
  logic [DEB_W-1:0]  deb_q,   deb_d;
  logic [TICK_W-1:0] tick_q,  tick_d;
  logic [15:0]       secs_q,  secs_d;
  logic              arrive_q, arrive_d;
  logic              depart_q, depart_d;
  logic              occ_q,    occ_d;

  logic parked_s;
  logic in_stay;

  assign parked_s = sync2_q;
  assign in_stay  = (state_q == OCCUPIED) || (state_q == DEPARTING);

  // ---- Next-state logic: debounce FSM, tick counter, seconds counter ----
  always_comb begin
    state_d  = state_q;
    deb_d    = deb_q;
    tick_d   = tick_q;
    secs_d   = secs_q;
    arrive_d = 1'b0;
    depart_d = 1'b0;

    case (state_q)
      EMPTY: begin
        if (parked_s) begin
          state_d = ARRIVING;
          deb_d   = '0;
        end
      end

      ARRIVING: begin
        if (!parked_s) begin
          // Sensor dropped before the debounce window filled: a glitch.
          state_d = EMPTY;
        end else if (deb_q == DEB_LAST) begin
          state_d  = OCCUPIED;
          arrive_d = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end

      OCCUPIED: begin
        if (!parked_s) begin
          state_d = DEPARTING;
          deb_d   = '0;
        end
      end

      DEPARTING: begin
        if (parked_s) begin
          // Car still there; the stay continues without interruption.
          state_d = OCCUPIED;
        end else if (deb_q == DEB_LAST) begin
          state_d  = EMPTY;
          depart_d = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end

      default: begin
        state_d = EMPTY;
        deb_d   = '0;
      end
    endcase

    // A new stay restarts the meter. Otherwise time advances only while a
    // car is accepted as present, and is frozen between stays.
    if (arrive_d) begin
      tick_d = '0;
      secs_d = '0;
    end else if (in_stay) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        secs_d = sat_inc(secs_q);
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end

    occ_d = (state_d == OCCUPIED) || (state_d == DEPARTING);
  end

  // ---- Register stage: synchronizer, FSM and registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= EMPTY;
      deb_q    <= '0;
      tick_q   <= '0;
      secs_q   <= '0;
      arrive_q <= 1'b0;
      depart_q <= 1'b0;
      occ_q    <= 1'b0;
    end else begin
      sync1_q  <= parked;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      deb_q    <= deb_d;
      tick_q   <= tick_d;
      secs_q   <= secs_d;
      arrive_q <= arrive_d;
      depart_q <= depart_d;
      occ_q    <= occ_d;
    end
  end

  assign occupied  = occ_q;
  assign arrive    = arrive_q;
  assign depart    = depart_q;
  assign park_secs = secs_q;

endmodule

// File: tb/tb_occupancy_tracker.sv
// ---------------------------------------------------------------------------
// tb_occupancy_tracker
//
// Directed bench with DEBOUNCE_CYCLES=4, TICK_CYCLES=10 on the main DUT and
// a second DUT with TICK_CYCLES=1 to exercise park_secs saturation.
// ---------------------------------------------------------------------------
module tb_occupancy_tracker;

  logic        clk;
  logic        rst;
  logic        parked;
  logic        occupied;
  logic        arrive;
  logic        depart;
  logic [15:0] park_secs;

  logic        parked2;
  logic        occupied2;
  logic        arrive2;
  logic        depart2;
  logic [15:0] park_secs2;

  int checks;
  int errors;

  occupancy_tracker #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .parked   (parked),
    .occupied (occupied),
    .arrive   (arrive),
    .depart   (depart),
    .park_secs(park_secs)
  );

  occupancy_tracker #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (1)
  ) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .parked   (parked2),
    .occupied (occupied2),
    .arrive   (arrive2),
    .depart   (depart2),
    .park_secs(park_secs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    parked  = 1'b0;
    parked2 = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_occupied", 32'(occupied), 32'd0);
    chk("rst_arrive",   32'(arrive),   32'd0);
    chk("rst_depart",   32'(depart),   32'd0);
    chk("rst_secs",     32'(park_secs), 32'd0);
    step(2);
    rst = 1'b0;

    // Arrival: first edge sampling parked=1 is edge 1, arrive after edge 7
    parked = 1'b1;
    step(6);
    chk("arr_e6_arrive",   32'(arrive),   32'd0);
    chk("arr_e6_occupied", 32'(occupied), 32'd0);
    step(1);
    chk("arr_e7_arrive",   32'(arrive),    32'd1);
    chk("arr_e7_occupied", 32'(occupied),  32'd1);
    chk("arr_e7_secs",     32'(park_secs), 32'd0);
    step(1);
    chk("arr_e8_arrive",   32'(arrive),    32'd0);

    // Seconds at arrival+9, +10, +20, +30, +35
    step(8);
    chk("secs_a9",  32'(park_secs), 32'd0);
    step(1);
    chk("secs_a10", 32'(park_secs), 32'd1);
    step(10);
    chk("secs_a20", 32'(park_secs), 32'd2);
    step(10);
    chk("secs_a30", 32'(park_secs), 32'd3);
    step(5);
    chk("secs_a35", 32'(park_secs), 32'd3);

    // Short dropout while occupied: no depart, meter keeps running
    parked = 1'b0;
    step(3);
    parked = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("glitch_occ_depart",   32'(depart),   32'd0);
      chk("glitch_occ_occupied", 32'(occupied), 32'd1);
    end
    chk("glitch_occ_secs", 32'(park_secs), 32'd4);

    // Departure: wrap at arrival+50 lands before depart at arrival+52
    parked = 1'b0;
    step(6);
    chk("dep_e6_depart",   32'(depart),   32'd0);
    chk("dep_e6_occupied", 32'(occupied), 32'd1);
    step(1);
    chk("dep_e7_depart",   32'(depart),    32'd1);
    chk("dep_e7_arrive",   32'(arrive),    32'd0);
    chk("dep_e7_occupied", 32'(occupied),  32'd0);
    chk("dep_e7_secs",     32'(park_secs), 32'd5);
    step(1);
    chk("dep_e8_depart", 32'(depart), 32'd0);
    step(20);
    chk("empty_hold_secs",     32'(park_secs), 32'd5);
    chk("empty_hold_occupied", 32'(occupied),  32'd0);

    // Short blip while empty: no arrival, secs untouched
    parked = 1'b1;
    step(3);
    parked = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("glitch_emp_arrive",   32'(arrive),   32'd0);
      chk("glitch_emp_occupied", 32'(occupied), 32'd0);
    end
    chk("glitch_emp_secs", 32'(park_secs), 32'd5);

    // New stay, then reset mid-stay at park_secs=5
    parked = 1'b1;
    step(7);
    chk("arr2_arrive", 32'(arrive),    32'd1);
    chk("arr2_secs",   32'(park_secs), 32'd0);
    step(50);
    chk("arr2_secs50",     32'(park_secs), 32'd5);
    chk("arr2_occupied50", 32'(occupied),  32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_occupied", 32'(occupied),  32'd0);
    chk("mrst_secs",     32'(park_secs), 32'd0);
    chk("mrst_arrive",   32'(arrive),    32'd0);
    chk("mrst_depart",   32'(depart),    32'd0);
    step(1);
    chk("mrst_hold_occupied", 32'(occupied), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("post_rst_depart", 32'(depart), 32'd0);
      chk("post_rst_arrive", 32'(arrive), 32'd0);
    end
    step(1);
    chk("post_rst_arrive_e7",   32'(arrive),    32'd1);
    chk("post_rst_occupied_e7", 32'(occupied),  32'd1);
    chk("post_rst_secs_e7",     32'(park_secs), 32'd0);

    // Saturation: TICK_CYCLES=1 adds one second per cycle in a stay
    parked2 = 1'b1;
    step(7);
    chk("sat_arrive", 32'(arrive2),    32'd1);
    chk("sat_secs0",  32'(park_secs2), 32'd0);
    step(65534);
    chk("sat_secs_65534", 32'(park_secs2), 32'd65534);
    step(1);
    chk("sat_secs_65535", 32'(park_secs2), 32'd65535);
    step(5);
    chk("sat_secs_hold", 32'(park_secs2), 32'd65535);
    chk("sat_occupied",  32'(occupied2),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
